// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: MEM-stage store port, load-forwarding port and the
// data RAM write port.
//   master : the pipeline / RAM side (drives st_*, ld_req, ld_addr, mem_busy)
//   slave  : the store buffer (drives st_ready, ld_*, MemWrite, mem_*, full, empty)
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_busy;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        full;
  logic        empty;

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, mem_busy,
    input  st_ready, ld_hit, ld_data, ld_stall, MemWrite, mem_addr, mem_wdata, full, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_busy,
    output st_ready, ld_hit, ld_data, ld_stall, MemWrite, mem_addr, mem_wdata, full, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending {addr, data} stores drained to the
// data RAM whenever its port is free, in strict program order.
// Ports:
//   clk   - system clock, rising-edge state updates
//   rst_n - asynchronous active-low reset, discards all pending stores
//   bus   - store_buffer_if.slave: store input (st_valid/st_addr/st_data/st_ready),
//           load lookup (ld_req/ld_addr/ld_hit/ld_data/ld_stall),
//           RAM write port (mem_busy/MemWrite/mem_addr/mem_wdata), status (full/empty)
// Configuration:
//   STORE_FWD_EN defined   - word-address forwarding from the youngest matching
//                            entry, ld_stall tied to 0
//   STORE_FWD_EN undefined - no comparators, ld_hit/ld_data tied to 0,
//                            ld_stall = ld_req && !empty
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // Entry storage is deliberately not reset; count_q alone defines validity.
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];

  logic full, empty, enq, deq;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // A full buffer never takes a store, even if it drains in the same cycle.
  assign enq   = bus.st_valid && !full;
  assign deq   = !empty && !bus.mem_busy;

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.st_ready  = !full;
  assign bus.MemWrite  = deq;
  assign bus.mem_addr  = empty ? 32'h0 : addr_q[head_q];
  assign bus.mem_wdata = empty ? 32'h0 : data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PtrW'(1);
    if (deq) head_d = head_q + PtrW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end

`ifdef STORE_FWD_EN
  logic            fwd_hit;
  logic [31:0]     fwd_data;
  logic [PtrW-1:0] idx;
  logic            unused_ld_addr;

  assign unused_ld_addr = ^bus.ld_addr[1:0];

  // Walk oldest to youngest so the last match (closest to tail) wins. The head
  // entry stays valid here even while it is being written to RAM.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'h0;
    idx      = head_q;
    if (bus.ld_req) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + PtrW'(k);
        if ((CntW'(k) < count_q) && (addr_q[idx][31:2] == bus.ld_addr[31:2])) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end
      end
    end
  end

  assign bus.ld_hit   = fwd_hit;
  assign bus.ld_data  = fwd_data;
  assign bus.ld_stall = 1'b0;
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^bus.ld_addr;
  assign bus.ld_hit     = 1'b0;
  assign bus.ld_data    = 32'h0;
  // Without forwarding any load must wait until every older store is in RAM.
  assign bus.ld_stall   = bus.ld_req && !empty;
`endif

endmodule
